// File: rtl/sram_bus_arbiter.sv
// Merges the core's instruction and data sram-like ports onto one memory port.
// Data has fixed priority; an in-order tag FIFO routes each response back to its requester.
module sram_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD_I = 2'd1;
  localparam logic [1:0] ST_HOLD_D = 2'd2;

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_nxt;
  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic [PtrW-1:0]            r_wr_ptr;
  logic [PtrW-1:0]            r_rd_ptr;
  logic [CntW-1:0]            r_count;

  logic w_full;
  logic w_sel_data;
  logic w_req;
  logic w_accept;
  logic w_pop;
  logic w_head_data;

  assign w_full = (r_count == CntW'(MAX_OUTSTANDING));

  // Source selection: re-arbitrate only in IDLE; a held request stays locked to its port.
  always_comb begin
    w_sel_data = 1'b0;
    w_req      = 1'b0;
    unique case (r_state)
      ST_HOLD_I: begin
        w_sel_data = 1'b0;
        w_req      = 1'b1;
      end
      ST_HOLD_D: begin
        w_sel_data = 1'b1;
        w_req      = 1'b1;
      end
      default: begin
        w_sel_data = data_req;
        w_req      = data_req | inst_req;
      end
    endcase
    w_req = w_req & ~w_full & ~reset;
  end

  assign w_accept    = w_req & mem_addr_ok;
  assign w_pop       = mem_data_ok & (r_count != '0) & ~reset;
  assign w_head_data = r_tags[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE && w_req) begin
      w_state_nxt = w_sel_data ? ST_HOLD_D : ST_HOLD_I;
    end else if (r_state != ST_HOLD_I && r_state != ST_HOLD_D) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tags[r_wr_ptr] <= w_sel_data;
        r_wr_ptr         <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Instruction fetches are always 32-bit reads with no strobes.
  assign mem_req   = w_req;
  assign mem_wr    = w_req & w_sel_data & data_wr;
  assign mem_wstrb = (w_req & w_sel_data) ? data_wstrb : 4'b0;
  assign mem_size  = !w_req ? 3'd0 : (w_sel_data ? data_size : 3'd2);
  assign mem_addr  = !w_req ? 32'b0 : (w_sel_data ? data_addr : inst_addr);
  assign mem_wdata = (w_req & w_sel_data) ? data_wdata : 32'b0;

  assign inst_addr_ok = w_accept & ~w_sel_data;
  assign data_addr_ok = w_accept & w_sel_data;
  assign inst_data_ok = w_pop & ~w_head_data;
  assign data_data_ok = w_pop & w_head_data;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule
